// File: rtl/vlsu_pkg.sv
// Shared helpers for the VLSU control machine: channel-id width and round-robin pointer advance.
package vlsu_pkg;

  // A single channel still needs a one-bit id field so the meta struct stays well formed.
  function automatic int cm_cid_width(input int nr_channels);
    return (nr_channels > 1) ? $clog2(nr_channels) : 1;
  endfunction

  function automatic int cm_rr_next(input int winner, input int nr_channels);
    return (winner == nr_channels - 1) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/cm_meta_fifo.sv
// Synchronous meta FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module cm_meta_fifo #(
  parameter int Depth = 4,
  parameter type entry_t = logic,
  localparam int PtrW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  entry_t          push_data,
  input  logic            pop,
  output entry_t          head,
  output logic            full,
  output logic            empty,
  output logic [PtrW-1:0] count
);

  entry_t mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PtrW-1] != rd_ptr[PtrW-1]) &&
                   (wr_ptr[PtrW-2:0] == rd_ptr[PtrW-2:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PtrW-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: an entry is only visible once its write pointer has moved past it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PtrW-2:0]] <= push_data;
  end

endmodule

// File: rtl/vcontrol_machine_mc.sv
// Multi-channel VLSU control machine: round-robin request arbiter, meta FIFO, write-outstanding tracking.
// Define VLSU_CM_LD_ST_ORDER_EN to hold loads while stores are in flight or pending in the core.
module vcontrol_machine_mc
  import vlsu_pkg::*;
#(
  parameter int NrChannels     = 2,
  parameter int MetaDepth      = 4,
  parameter int PayloadW       = 64,
  parameter int MaxOutstanding = 8,
  localparam int CidW  = cm_cid_width(NrChannels),
  localparam int CntW  = $clog2(MaxOutstanding + 1),
  localparam int MetaW = PayloadW + 1 + CidW
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrChannels-1:0]          req_valid_i,
  output logic [NrChannels-1:0]          req_ready_o,
  input  logic [NrChannels-1:0]          req_store_i,
  input  logic [NrChannels*PayloadW-1:0] req_payload_i,
  input  logic                           core_st_pending_i,
  output logic                           meta_valid_o,
  input  logic                           meta_ready_i,
  output logic [MetaW-1:0]               meta_o,
  input  logic                           aw_issue_i,
  output logic                           aw_stall_o,
  input  logic                           b_valid_i,
  output logic                           b_ready_o,
  output logic [CntW-1:0]                st_outstanding_o,
  output logic                           idle_o,
  output logic                           err_o
);

  localparam int FifoPtrW = $clog2(MetaDepth) + 1;

  typedef struct packed {
    logic [PayloadW-1:0] payload;
    logic                is_store;
    logic [CidW-1:0]     chan_id;
  } cm_meta_t;

  logic [CidW-1:0]     rr_ptr;
  logic [CntW-1:0]     outstanding;
  logic                err_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FifoPtrW-1:0] fifo_count;
  cm_meta_t            fifo_head;
  cm_meta_t            push_entry;
  logic [NrChannels-1:0] eligible;
  logic                grant;
  logic [CidW-1:0]     winner;
  logic                ld_ok;
  logic                cnt_at_max;
  logic                cnt_zero;
  logic                b_hs;
  logic                err_aw;
  logic                err_b;

  assign cnt_at_max = (outstanding == CntW'(MaxOutstanding));
  assign cnt_zero   = (outstanding == '0);

`ifdef VLSU_CM_LD_ST_ORDER_EN
  assign ld_ok = cnt_zero && !core_st_pending_i;
`else
  logic core_st_pending_unused;
  assign core_st_pending_unused = core_st_pending_i;
  assign ld_ok = 1'b1;
`endif

  always_comb begin
    for (int c = 0; c < NrChannels; c++) begin
      eligible[c] = req_valid_i[c] && !fifo_full && (req_store_i[c] || ld_ok);
    end
  end

  // Scan starts at rr_ptr and wraps, so the first eligible channel found is the round-robin winner.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int i = 0; i < NrChannels; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NrChannels) idx = idx - NrChannels;
      if (!grant && eligible[idx]) begin
        grant  = 1'b1;
        winner = CidW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant && !rst_i) req_ready_o[winner] = 1'b1;
  end

  always_comb begin
    push_entry.payload  = req_payload_i[int'(winner)*PayloadW +: PayloadW];
    push_entry.is_store = req_store_i[winner];
    push_entry.chan_id  = winner;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= CidW'(cm_rr_next(int'(winner), NrChannels));
    end
  end

  cm_meta_fifo #(
    .Depth   (MetaDepth),
    .entry_t (cm_meta_t)
  ) u_meta_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (grant),
    .push_data (push_entry),
    .pop       (meta_ready_i),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign meta_valid_o = !fifo_empty;
  assign meta_o       = fifo_head;

  assign b_ready_o = !cnt_zero;
  assign b_hs      = b_valid_i && b_ready_o;
  assign err_aw    = aw_issue_i && cnt_at_max;
  assign err_b     = b_valid_i && cnt_zero;

  // Any protocol error freezes the count so it never wraps past either bound.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
      err_q       <= 1'b0;
    end else begin
      if (err_aw || err_b) begin
        err_q <= 1'b1;
      end else if (aw_issue_i && !b_hs) begin
        outstanding <= outstanding + 1'b1;
      end else if (b_hs && !aw_issue_i) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  assign st_outstanding_o = outstanding;
  assign aw_stall_o       = cnt_at_max;
  assign idle_o           = (fifo_count == '0) && cnt_zero;
  assign err_o            = err_q;

endmodule

// File: doc/vcontrol_machine_mc.md
# vcontrol_machine_mc

Multi-channel control machine for the VLSU front end. It accepts vector memory requests on `NrChannels` independent requester ports and arbitrates them round-robin into an internal meta FIFO of depth `MetaDepth`. It tracks outstanding AXI write transactions (issued AW minus returned B) and optionally enforces load-after-store ordering. It sits between the requesters and the transaction control unit, replacing the single-port control machine and its external meta buffer.

## Interface
- `NrChannels`, 2: number of requester ports, 1..8
- `MetaDepth`, 4: meta FIFO entries, power of two, ≥2
- `PayloadW`, 64: opaque request payload width
- `MaxOutstanding`, 8: maximum in-flight write transactions, ≥1
- `clk_i` in 1: clock
- `rst_i` in 1: reset, asynchronous, active-high
- `req_valid_i` in NrChannels: per-channel request valid
- `req_ready_o` out NrChannels: per-channel grant; at most one bit high per cycle
- `req_store_i` in NrChannels: 1 = store request, 0 = load request
- `req_payload_i` in NrChannels×PayloadW: per-channel payload, packed with channel 0 at the LSBs
- `core_st_pending_i` in 1: scalar core has stores not yet visible
- `meta_valid_o` out 1: FIFO head valid
- `meta_ready_i` in 1: consumer pops the head
- `meta_o` out cm_meta_t: head entry {payload, is_store, chan_id}
- `aw_issue_i` in 1: one-cycle pulse per AW handshake downstream
- `aw_stall_o` out 1: outstanding count == MaxOutstanding; the downstream block must not issue AW
- `b_valid_i` in 1: write response valid
- `b_ready_o` out 1: write response accept
- `st_outstanding_o` out $clog2(MaxOutstanding+1): current outstanding count
- `idle_o` out 1: FIFO empty and outstanding count == 0
- `err_o` out 1: sticky protocol error

## Operation
- Eligibility: a channel is eligible when its `req_valid_i` is high and the FIFO is not full. With ordering enabled, a load request additionally needs outstanding == 0 and `core_st_pending_i` low. A store request is never blocked by ordering.
- Arbitration: round-robin among eligible channels, starting from `rr_ptr`. The winner gets `req_ready_o` high. On a grant, `rr_ptr` is set to winner+1, wrapping to 0 at `NrChannels`. `rr_ptr` is unchanged when there is no grant.
- Enqueue: on grant, push {payload, store, chan_id} into the FIFO.
- Full FIFO: no grant, even if `meta_ready_i` is high that cycle. There is no pass-through.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged.
- Dequeue: pop when `meta_valid_o && meta_ready_i`.
- Outstanding counter:
  - +1 on `aw_issue_i`.
  - −1 on a B handshake.
  - Both in the same cycle: unchanged.
- `b_ready_o` = 1 whenever outstanding > 0.
- Error conditions: `err_o` is set on `aw_issue_i` while outstanding == MaxOutstanding, or on `b_valid_i` while outstanding == 0. On either error the counter holds. `err_o` is cleared only by reset.

## Timing
- Reset state:
  - `rr_ptr` = 0, FIFO empty, outstanding = 0, `err_o` = 0.
  - `meta_valid_o` = 0, `b_ready_o` = 0, `aw_stall_o` = 0, `idle_o` = 1.
  - `req_ready_o` = 0 while reset is asserted.
  - Reset mid-operation drops all FIFO contents and the outstanding count immediately.
- `req_ready_o` is combinational from `req_valid_i`, `req_store_i`, FIFO count, `rr_ptr`, outstanding count and `core_st_pending_i`. It has no path from `meta_ready_i`.
- Latency: an entry granted in cycle N appears at the FIFO head (`meta_valid_o` = 1) in N+1 if the FIFO was empty.
- `meta_o` is held stable while `meta_valid_o && !meta_ready_i`.
- `st_outstanding_o`, `aw_stall_o` and `idle_o` are registered-state outputs that reflect the count after the previous edge.
- A load blocked by ordering becomes eligible in the cycle after the counter reaches 0, assuming `core_st_pending_i` is low.

## Configuration
- `VLSU_CM_LD_ST_ORDER_EN` defined: the load ordering rule above is applied.
- `VLSU_CM_LD_ST_ORDER_EN` undefined: loads are eligible regardless of the outstanding count and `core_st_pending_i`.
- Both modes: counter, stall and error logic are always present.

## Structure
- `vlsu_pkg` holds:
  - `cm_meta_t` (PayloadW-parametrised via a typedef in the instantiating scope, or a type parameter).
  - the chan_id width function `$clog2(NrChannels)` with a minimum of 1.
- Sub-module `cm_meta_fifo`: synchronous FIFO with `full`/`empty` flags and a count.
  - Pointers are `$clog2(MetaDepth)+1` bits wide; the extra MSB distinguishes full from empty at wrap-around.
- Arbiter, counter and error logic live in the top module.

## Test plan
- Single load from channel 1 on an empty, idle block:
  - `req_ready_o` = 2'b10 in the same cycle.
  - Next cycle: `meta_valid_o` = 1 and `meta_o.chan_id` = 1.
  - `rr_ptr` becomes 0.
- Both channels valid continuously with `meta_ready_i` = 1: grants alternate 0,1,0,1 and FIFO occupancy stays ≤1.
- `meta_ready_i` = 0 with 5 requests offered (MetaDepth = 4):
  - Exactly 4 grants, then `req_ready_o` = 0.
  - Raise `meta_ready_i` for one cycle: one pop, and the next grant follows in the following cycle.
- Ordering enabled:
  - Setup: 3 `aw_issue_i` pulses, then a load request.
  - Load is held while `st_outstanding_o` = 3→0.
  - Load is granted the cycle after the 3rd B handshake.
  - With the macro undefined, the same load is granted immediately.
- `aw_issue_i` and a B handshake in the same cycle at count 2: count stays 2 and `err_o` = 0.
- Protocol errors:
  - B at count 0 → `err_o` = 1, count = 0.
  - 9 issues with MaxOutstanding = 8 → `aw_stall_o` = 1 after the 8th, `err_o` = 1 on the 9th, count = 8.
- Async reset asserted mid-burst with FIFO = 3 and count = 5: all outputs return to their reset values without waiting for a clock edge.
